// File: rtl/data_mem_responder_pkg.sv
// Shared types and default widths for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the CPU memory stage (master) and the responder (slave).
interface data_mem_responder_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port synchronous RAM; read data is registered and holds until the next read.
module dmem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accept, wait states, single access, hold response until taken.
// Optional access counters are enabled by defining DMEM_STATS_EN.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting down programmed wait states
// ACCESS | one-cycle array read/write or range error
// RESP   | response presented until rsp_ready
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_responder_if.slave bus,
  output logic                busy
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count,
  output logic [15:0]         err_count
`endif
);
  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              rsel_q;
  logic              accept, done, in_range, is_access;
  logic [DATA_W-1:0] ram_rdata;

  assign accept    = (state_q == IDLE) && bus.req_valid;
  assign done      = (state_q == RESP) && bus.rsp_ready;
  assign is_access = (state_q == ACCESS);
  assign in_range  = 32'(addr_q) < 32'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at accept so the CPU may change its outputs freely afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      rsel_q <= 1'b0;
    end else if (is_access) begin
      err_q  <= !in_range;
      rsel_q <= in_range && !we_q;
    end else if (done) begin
      err_q  <= 1'b0;
      rsel_q <= 1'b0;
    end
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (is_access && in_range && we_q),
    .re_i    (is_access && in_range && !we_q),
    .idx_i   (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // The RAM output register is uninitialised, so it is only exposed after a valid load.
  assign bus.rsp_rdata = rsel_q ? ram_rdata : '0;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign busy          = (state_q != IDLE);

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (is_access) begin
      if (!in_range) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (we_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: vector table on a WAIT_CYCLES=2 instance plus hand sequences and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clk;
  logic rst_n;
  logic busy, busy0;
  int   total = 0;
  int   bad   = 0;

  data_mem_responder_if #(.ADDR_W(16), .DATA_W(32)) bus  ();
  data_mem_responder_if #(.ADDR_W(16), .DATA_W(32)) bus0 ();

`ifdef DMEM_STATS_EN
  logic [15:0] rd_count, wr_count, err_count;
  logic [15:0] rd_count0, wr_count0, err_count0;
`endif

  data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
`ifdef DMEM_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .err_count (err_count)
`endif
  );

  data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave),
    .busy  (busy0)
`ifdef DMEM_STATS_EN
    ,
    .rd_count  (rd_count0),
    .wr_count  (wr_count0),
    .err_count (err_count0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns at the negedge where rsp_valid is first seen.
  task automatic txn(input bit we, input logic [15:0] addr, input logic [31:0] wd, input bit rdy,
                     output logic [31:0] rd, output logic er, output int lat);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.rsp_ready = rdy;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = !we;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wd;
    lat = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  task automatic txn0(input bit we, input logic [15:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat);
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wd;
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus0.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = bus0.rsp_rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    vecs[0] = '{1'b1, 16'h0005, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 16'h0005, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'h00FF, 32'hA5A50FF0, 32'h0,        1'b0};
    vecs[3] = '{1'b1, 16'h0000, 32'h00000001, 32'h0,        1'b0};
    vecs[4] = '{1'b1, 16'h0100, 32'h11112222, 32'h0,        1'b1};
    vecs[5] = '{1'b0, 16'h0100, 32'h0,        32'h0,        1'b1};
    vecs[6] = '{1'b0, 16'h00FF, 32'h0,        32'hA5A50FF0, 1'b0};
    vecs[7] = '{1'b0, 16'h0000, 32'h0,        32'h00000001, 1'b0};
    vecs[8] = '{1'b1, 16'hFFFF, 32'hCAFEF00D, 32'h0,        1'b1};
    vecs[9] = '{1'b0, 16'h0005, 32'h0,        32'hDEADBEEF, 1'b0};

    rst_n = 1'b0;
    bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0; bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b0;
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'h0);
    chk("rst_busy",      32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b1, rd, er, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_valid", i), 32'(bus.rsp_valid), 32'h0);
    end

`ifdef DMEM_STATS_EN
    chk("stats_rd",  32'(rd_count),  32'd4);
    chk("stats_wr",  32'(wr_count),  32'd3);
    chk("stats_err", 32'(err_count), 32'd3);
`endif

    // Back-pressure: response held, new request ignored.
    txn(1'b0, 16'h0005, 32'h0, 1'b0, rd, er, lat);
    chk("bp_latency", 32'(lat), 32'd3);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0005;
    bus.req_wdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), 32'(bus.rsp_valid), 32'h1);
      chk($sformatf("bp%0d_rdata", c), bus.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp%0d_err", c),   32'(bus.rsp_err), 32'h0);
      chk($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'h0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'h0);
    chk("bp_release_busy",  32'(busy), 32'h0);
    txn(1'b0, 16'h0005, 32'h0, 1'b1, rd, er, lat);
    chk("bp_no_store", rd, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Reset while a store sits in WAIT.
    txn(1'b1, 16'h0010, 32'h0, 1'b1, rd, er, lat);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0010;
    bus.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstw_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstw_busy",      32'(busy), 32'h0);
    chk("rstw_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rstw_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rstw_rsp_err",   32'(bus.rsp_err), 32'h0);
`ifdef DMEM_STATS_EN
    chk("rstw_stats_rd", 32'(rd_count), 32'h0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 16'h0010, 32'h0, 1'b1, rd, er, lat);
    chk("rstw_mem_unchanged", rd, 32'h0);
    @(posedge clk); #1;

    // Zero wait states.
    txn0(1'b1, 16'h0020, 32'h00000077, rd, lat);
    chk("w0_store_latency", 32'(lat), 32'd1);
    txn0(1'b0, 16'h0020, 32'h0, rd, lat);
    chk("w0_load_latency", 32'(lat), 32'd1);
    chk("w0_load_rdata", rd, 32'h00000077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
